ldst_multi_expander: RTL and testbench
======================================

# ldst_multi_expander

Parametrised micro-op expander between the IF/ID pipeline register and the instruction decoder. It passes ordinary instructions through with one cycle of latency. It expands each load-multiple (LDM) or store-multiple (STM) instruction into 1..MAX_CNT consecutive LDW/STW micro-ops, holding the fetch stage while the sequence is issued. Illegal LDM forms are rewritten to an undefined opcode, so the downstream decoder raises the undefined-instruction exception.

## Interface
- DATA_W, 32, instruction/data width
- ADDR_W, 30, word-address (PC) width
- REG_AW, 5, register address width
- MAX_CNT, 8, max words per LDM/STM; power of two, 2..16; CNT_W = log2(MAX_CNT)
- OP_LDM / OP_STM, 6'h1c / 6'h1d, multi-word opcodes
- OP_LDW / OP_STW, 6'h16 / 6'h17, single-word opcodes emitted
- OP_UNDEF, 6'h3f, opcode substituted for illegal forms

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset (one clock; reset is asynchronous and active-high)
- stall  in  1  freeze all state and outputs
- flush  in  1  synchronous pipeline flush
- if_pc  in  ADDR_W  fetched PC
- if_insn  in  DATA_W  fetched instruction
- if_en  in  1  fetched instruction valid
- if_hold  out  1  fetch must hold its current instruction (combinational from state)
- mop_pc  out  ADDR_W  PC of the originating instruction
- mop_insn  out  DATA_W  instruction/micro-op to the decoder
- mop_en  out  1  mop valid
- mop_idx  out  CNT_W  index of the micro-op within its sequence; 0 for pass-through
- mop_last  out  1  final (or only) mop of an instruction

## Operation

Instruction fields:
- op = insn[31:26], ra = [25:21], rb = [20:16], imm = [15:0].
- For LDM/STM, the field imm[CNT_W-1:0] gives the count minus one: N = field + 1. The remaining imm bits are ignored.

States: IDLE and SEQ.

IDLE, edge with stall = 0 and flush = 0:
- The input is accepted.
- If op is not LDM/STM, or if_en = 0:
  - mop_insn = if_insn, mop_pc = if_pc, mop_en = if_en.
  - mop_idx = 0, mop_last = if_en.
- If op is LDM/STM and if_en = 1, the expander latches ra, the first rb, N, the opcode kind and the PC, then emits micro-op 0.
- Micro-op k, for k = 0..N-1, is encoded as:
  - op = LDW for LDM, STW for STM.
  - ra unchanged; rb = (rb0 + k) mod 2^REG_AW, so register numbers wrap.
  - imm = 4·k, a byte offset; the imm width is fixed at 16.
  - mop_idx = k; mop_last = (k == N-1).
- After emitting micro-op 0: if N > 1, the state becomes SEQ with k = 1; if N = 1, the state stays IDLE.

SEQ, edge with stall = 0 and flush = 0:
- The expander emits micro-op k with mop_en = 1 and ignores the input.
- k increments; the state returns to IDLE after micro-op N-1 is emitted.

if_hold = (state == SEQ).

Illegal LDM: ra lies within the destination range {rb0 .. rb0+N-1 mod 2^REG_AW}.
- The expander emits one op with mop_insn = if_insn and op replaced by OP_UNDEF, mop_last = 1, and stays IDLE.
- STM has no illegal form.

Priority: stall > flush > normal.
- stall = 1: all registers hold, including state, k and outputs.
- flush = 1 with stall = 0: mop_en ← 0, mop_last ← 0, state ← IDLE, k ← 0; mop_insn ← 0 (NOP).

## Timing
- Reset values: mop_pc = 0, mop_insn = 0, mop_en = 0, mop_idx = 0, mop_last = 0, state IDLE, k = 0, if_hold = 0.
- Reset asserted mid-sequence aborts the sequence immediately; it is asynchronous.
- Latency: 1 cycle from the input edge to the registered output.
- LDM/STM accepted at edge E0 produces micro-op k at edge Ek.
- if_hold is high from after E0 until after E(N-1), i.e. for N-1 cycles; the next instruction is accepted at edge EN.
- A stall during SEQ stretches the sequence one cycle per stalled cycle, with if_hold remaining high.
- Flush during SEQ drops the remaining micro-ops; if_hold falls in the next cycle.

## Test plan
- Pass-through: ADDSR insn 32'h20221800 at PC 0x10, if_en = 1 → next cycle mop_insn = 32'h20221800, mop_pc = 0x10, mop_en = 1, mop_last = 1, mop_idx = 0, if_hold = 0.
- LDM ra = 2, rb = 4, field 3 (N = 4):
  - micro-ops LDW r4/r5/r6/r7 with imm 0/4/8/12 on 4 consecutive cycles.
  - mop_last only on idx 3; if_hold high for exactly 3 cycles; the following ORR emits on cycle 5.
- STM rb = 30, N = 4 → rb sequence 30, 31, 0, 1 (wrap); op STW; same mop_pc on all four.
- Illegal LDM ra = 5, rb = 4, N = 3 → a single op with op = 6'h3f, mop_last = 1, if_hold never asserted.
- Stall of 2 cycles at idx 1 of an N = 4 LDM → idx 1 is held for 3 cycles, then idx 2 and idx 3 follow; no duplicate or skipped index.
- Flush at idx 2 of N = 8 → next mop_en = 0, state IDLE, if_hold = 0.
- Async reset mid-sequence → all outputs zero without waiting for a clock edge.

Source files
------------

// File: rtl/ldst_multi_expander.sv
// Micro-op expander between IF/ID and the decoder: passes ordinary instructions
// through with one cycle of latency and expands LDM/STM into LDW/STW sequences.
module ldst_multi_expander #(
    parameter int          DATA_W   = 32,
    parameter int          ADDR_W   = 30,
    parameter int          REG_AW   = 5,
    parameter int          MAX_CNT  = 8,
    parameter logic [5:0]  OP_LDM   = 6'h1c,
    parameter logic [5:0]  OP_STM   = 6'h1d,
    parameter logic [5:0]  OP_LDW   = 6'h16,
    parameter logic [5:0]  OP_STW   = 6'h17,
    parameter logic [5:0]  OP_UNDEF = 6'h3f,
    localparam int         CNT_W    = $clog2(MAX_CNT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [DATA_W-1:0] if_insn,
    input  logic              if_en,
    output logic              if_hold,
    output logic [ADDR_W-1:0] mop_pc,
    output logic [DATA_W-1:0] mop_insn,
    output logic              mop_en,
    output logic [CNT_W-1:0]  mop_idx,
    output logic              mop_last
);

    typedef enum logic {IDLE, SEQ} state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  k, k_nx;
    logic [CNT_W-1:0]  n_m1, n_m1_nx;
    logic [REG_AW-1:0] ra_q, ra_nx;
    logic [REG_AW-1:0] rb0_q, rb0_nx;
    logic              is_ld_q, is_ld_nx;

    logic [ADDR_W-1:0] mop_pc_nx;
    logic [DATA_W-1:0] mop_insn_nx;
    logic              mop_en_nx;
    logic [CNT_W-1:0]  mop_idx_nx;
    logic              mop_last_nx;

    logic [5:0]        op_in;
    logic [REG_AW-1:0] ra_in, rb_in, span;
    logic [CNT_W-1:0]  field_in;
    logic              is_multi, illegal;

    // Micro-op k: same ra, rb advanced by k (wraps), byte offset 4*k.
    function automatic logic [DATA_W-1:0] micro_op(input logic ld,
                                                   input logic [REG_AW-1:0] ra,
                                                   input logic [REG_AW-1:0] rb0,
                                                   input logic [CNT_W-1:0] idx);
        logic [DATA_W-1:0] w;
        w        = '0;
        w[31:26] = ld ? OP_LDW : OP_STW;
        w[25:21] = ra;
        w[20:16] = rb0 + REG_AW'(idx);
        w[15:0]  = 16'(idx) << 2;
        return w;
    endfunction

    assign op_in    = if_insn[31:26];
    assign ra_in    = if_insn[25:21];
    assign rb_in    = if_insn[20:16];
    assign field_in = if_insn[CNT_W-1:0];
    assign is_multi = (op_in == OP_LDM) || (op_in == OP_STM);
    // ra is inside the destination window iff its distance above rb0 (mod 2^REG_AW) is < N.
    assign span     = ra_in - rb_in;
    assign illegal  = (op_in == OP_LDM) && (span <= REG_AW'(field_in));

    assign if_hold  = (state == SEQ);

    always_comb begin
        state_nx    = state;
        k_nx        = k;
        n_m1_nx     = n_m1;
        ra_nx       = ra_q;
        rb0_nx      = rb0_q;
        is_ld_nx    = is_ld_q;
        mop_pc_nx   = mop_pc;
        mop_insn_nx = mop_insn;
        mop_en_nx   = mop_en;
        mop_idx_nx  = mop_idx;
        mop_last_nx = mop_last;

        if (flush) begin
            state_nx    = IDLE;
            k_nx        = '0;
            mop_insn_nx = '0;
            mop_en_nx   = 1'b0;
            mop_idx_nx  = '0;
            mop_last_nx = 1'b0;
        end else if (state == SEQ) begin
            mop_insn_nx = micro_op(is_ld_q, ra_q, rb0_q, k);
            mop_en_nx   = 1'b1;
            mop_idx_nx  = k;
            mop_last_nx = (k == n_m1);
            if (k == n_m1) begin
                state_nx = IDLE;
                k_nx     = '0;
            end else begin
                k_nx = k + 1'b1;
            end
        end else if (!if_en || !is_multi) begin
            mop_insn_nx = if_insn;
            mop_pc_nx   = if_pc;
            mop_en_nx   = if_en;
            mop_idx_nx  = '0;
            mop_last_nx = if_en;
        end else if (illegal) begin
            mop_insn_nx = {OP_UNDEF, if_insn[DATA_W-7:0]};
            mop_pc_nx   = if_pc;
            mop_en_nx   = 1'b1;
            mop_idx_nx  = '0;
            mop_last_nx = 1'b1;
        end else begin
            ra_nx       = ra_in;
            rb0_nx      = rb_in;
            n_m1_nx     = field_in;
            is_ld_nx    = (op_in == OP_LDM);
            mop_insn_nx = micro_op(op_in == OP_LDM, ra_in, rb_in, '0);
            mop_pc_nx   = if_pc;
            mop_en_nx   = 1'b1;
            mop_idx_nx  = '0;
            mop_last_nx = (field_in == '0);
            if (field_in != '0) begin
                state_nx = SEQ;
                k_nx     = CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            k        <= '0;
            n_m1     <= '0;
            ra_q     <= '0;
            rb0_q    <= '0;
            is_ld_q  <= 1'b0;
            mop_pc   <= '0;
            mop_insn <= '0;
            mop_en   <= 1'b0;
            mop_idx  <= '0;
            mop_last <= 1'b0;
        end else if (!stall) begin
            state    <= state_nx;
            k        <= k_nx;
            n_m1     <= n_m1_nx;
            ra_q     <= ra_nx;
            rb0_q    <= rb0_nx;
            is_ld_q  <= is_ld_nx;
            mop_pc   <= mop_pc_nx;
            mop_insn <= mop_insn_nx;
            mop_en   <= mop_en_nx;
            mop_idx  <= mop_idx_nx;
            mop_last <= mop_last_nx;
        end
    end

endmodule

// File: tb/tb_ldst_multi_expander.sv
// Directed bench for ldst_multi_expander: pass-through, LDM/STM expansion,
// register wrap, illegal LDM, stall, flush and asynchronous reset.
module tb_ldst_multi_expander;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [29:0] if_pc;
    logic [31:0] if_insn;
    logic        if_en;
    logic        if_hold;
    logic [29:0] mop_pc;
    logic [31:0] mop_insn;
    logic        mop_en;
    logic [2:0]  mop_idx;
    logic        mop_last;

    int checks = 0;
    int errors = 0;

    ldst_multi_expander dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .flush    (flush),
        .if_pc    (if_pc),
        .if_insn  (if_insn),
        .if_en    (if_en),
        .if_hold  (if_hold),
        .mop_pc   (mop_pc),
        .mop_insn (mop_insn),
        .mop_en   (mop_en),
        .mop_idx  (mop_idx),
        .mop_last (mop_last)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        if (mop_insn !== 32'h0) begin errors++; $display("FAIL reset_insn got %h want 0", mop_insn); end
        checks++;
        if (mop_pc !== 30'h0) begin errors++; $display("FAIL reset_pc got %h want 0", mop_pc); end
        checks++;
        if ({mop_en, mop_last, if_hold, mop_idx} !== 6'b0) begin
            errors++; $display("FAIL reset_ctl got en=%b last=%b hold=%b idx=%0d want all 0", mop_en, mop_last, if_hold, mop_idx);
        end
        checks++;
        reset = 1'b0;
    endtask

    task automatic test_pass_through();
        if_insn = 32'h20221800; if_pc = 30'h10; if_en = 1'b1;
        tick();
        if (mop_insn !== 32'h20221800) begin errors++; $display("FAIL pass_insn got %h want 20221800", mop_insn); end
        checks++;
        if (mop_pc !== 30'h10) begin errors++; $display("FAIL pass_pc got %h want 10", mop_pc); end
        checks++;
        if ({mop_en, mop_last, if_hold, mop_idx} !== 6'b110_000) begin
            errors++; $display("FAIL pass_ctl got en=%b last=%b hold=%b idx=%0d want 1 1 0 0", mop_en, mop_last, if_hold, mop_idx);
        end
        checks++;
        // An LDM with if_en low is not expanded.
        if_insn = 32'h70440003; if_en = 1'b0;
        tick();
        if ({mop_en, mop_last, if_hold} !== 3'b000) begin
            errors++; $display("FAIL pass_invalid got en=%b last=%b hold=%b want 0 0 0", mop_en, mop_last, if_hold);
        end
        checks++;
    endtask

    task automatic test_ldm_seq();
        logic [31:0] exp_insn [4];
        exp_insn[0] = 32'h58440000; exp_insn[1] = 32'h58450004;
        exp_insn[2] = 32'h58460008; exp_insn[3] = 32'h5847000c;
        if_insn = 32'h70440003; if_pc = 30'h20; if_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) begin if_insn = 32'h24221800; if_pc = 30'h21; end
            if (mop_insn !== exp_insn[i]) begin errors++; $display("FAIL ldm_insn[%0d] got %h want %h", i, mop_insn, exp_insn[i]); end
            checks++;
            if (mop_idx !== 3'(i) || mop_last !== (i == 3) || mop_en !== 1'b1 || mop_pc !== 30'h20) begin
                errors++; $display("FAIL ldm_ctl[%0d] got idx=%0d last=%b en=%b pc=%h want %0d %b 1 20", i, mop_idx, mop_last, mop_en, mop_pc, i, i == 3);
            end
            checks++;
            if (if_hold !== (i < 3)) begin errors++; $display("FAIL ldm_hold[%0d] got %b want %b", i, if_hold, i < 3); end
            checks++;
        end
        tick();
        if (mop_insn !== 32'h24221800 || mop_pc !== 30'h21 || mop_last !== 1'b1 || mop_idx !== 3'd0) begin
            errors++; $display("FAIL ldm_next got insn=%h pc=%h last=%b idx=%0d want 24221800 21 1 0", mop_insn, mop_pc, mop_last, mop_idx);
        end
        checks++;
        if_en = 1'b0;
    endtask

    task automatic test_stm_wrap();
        logic [31:0] exp_insn [4];
        exp_insn[0] = 32'h5c3e0000; exp_insn[1] = 32'h5c3f0004;
        exp_insn[2] = 32'h5c200008; exp_insn[3] = 32'h5c21000c;
        if_insn = 32'h743e0003; if_pc = 30'h30; if_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) if_en = 1'b0;
            if (mop_insn !== exp_insn[i] || mop_pc !== 30'h30 || mop_idx !== 3'(i)) begin
                errors++; $display("FAIL stm[%0d] got insn=%h pc=%h idx=%0d want %h 30 %0d", i, mop_insn, mop_pc, mop_idx, exp_insn[i], i);
            end
            checks++;
        end
        tick();
        if (mop_en !== 1'b0 || if_hold !== 1'b0) begin errors++; $display("FAIL stm_end got en=%b hold=%b want 0 0", mop_en, if_hold); end
        checks++;
    endtask

    task automatic test_illegal();
        logic [31:0] vin [3];
        logic [31:0] vexp [3];
        // ra inside window, ra inside a wrapped window, legal N=1 with junk high imm bits.
        vin[0] = 32'h70a40002; vexp[0] = 32'hfca40002;
        vin[1] = 32'h703e0003; vexp[1] = 32'hfc3e0003;
        vin[2] = 32'h70010008; vexp[2] = 32'h58010000;
        for (int i = 0; i < 3; i++) begin
            if_insn = vin[i]; if_pc = 30'h40 + 30'(i); if_en = 1'b1;
            tick();
            if (mop_insn !== vexp[i] || mop_last !== 1'b1 || mop_en !== 1'b1 || mop_pc !== 30'h40 + 30'(i)) begin
                errors++; $display("FAIL single[%0d] got insn=%h last=%b en=%b pc=%h want %h 1 1 %h", i, mop_insn, mop_last, mop_en, mop_pc, vexp[i], 30'h40 + 30'(i));
            end
            checks++;
            if (if_hold !== 1'b0) begin errors++; $display("FAIL single_hold[%0d] got %b want 0", i, if_hold); end
            checks++;
        end
        if_en = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        if_insn = 32'h70440003; if_pc = 30'h50; if_en = 1'b1;
        tick();
        if_en = 1'b0;
        tick();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (mop_idx !== 3'd1 || mop_insn !== 32'h58450004 || if_hold !== 1'b1) begin
                errors++; $display("FAIL stall_hold[%0d] got idx=%0d insn=%h hold=%b want 1 58450004 1", i, mop_idx, mop_insn, if_hold);
            end
            checks++;
        end
        stall = 1'b0;
        tick();
        if (mop_idx !== 3'd2 || mop_insn !== 32'h58460008 || mop_last !== 1'b0) begin
            errors++; $display("FAIL stall_idx2 got idx=%0d insn=%h last=%b want 2 58460008 0", mop_idx, mop_insn, mop_last);
        end
        checks++;
        tick();
        if (mop_idx !== 3'd3 || mop_insn !== 32'h5847000c || mop_last !== 1'b1 || if_hold !== 1'b0) begin
            errors++; $display("FAIL stall_idx3 got idx=%0d insn=%h last=%b hold=%b want 3 5847000c 1 0", mop_idx, mop_insn, mop_last, if_hold);
        end
        checks++;
        tick();
    endtask

    task automatic test_flush();
        if_insn = 32'h70080007; if_pc = 30'h60; if_en = 1'b1;
        tick();
        if_en = 1'b0;
        repeat (2) tick();
        if (mop_idx !== 3'd2 || mop_insn !== 32'h580a0008 || if_hold !== 1'b1) begin
            errors++; $display("FAIL flush_pre got idx=%0d insn=%h hold=%b want 2 580a0008 1", mop_idx, mop_insn, if_hold);
        end
        checks++;
        flush = 1'b1;
        tick();
        if (mop_en !== 1'b0 || mop_last !== 1'b0 || mop_insn !== 32'h0 || if_hold !== 1'b0) begin
            errors++; $display("FAIL flush got en=%b last=%b insn=%h hold=%b want 0 0 0 0", mop_en, mop_last, mop_insn, if_hold);
        end
        checks++;
        flush = 1'b0;
        tick();
        if (mop_en !== 1'b0 || if_hold !== 1'b0) begin errors++; $display("FAIL flush_after got en=%b hold=%b want 0 0", mop_en, if_hold); end
        checks++;
    endtask

    task automatic test_async_reset();
        if_insn = 32'h70440003; if_pc = 30'h70; if_en = 1'b1;
        tick();
        if_en = 1'b0;
        tick();
        #3;
        reset = 1'b1;
        #1;
        if (mop_insn !== 32'h0 || mop_pc !== 30'h0 || {mop_en, mop_last, if_hold, mop_idx} !== 6'b0) begin
            errors++; $display("FAIL async_reset got insn=%h pc=%h en=%b last=%b hold=%b idx=%0d want all 0", mop_insn, mop_pc, mop_en, mop_last, if_hold, mop_idx);
        end
        checks++;
        tick();
        reset = 1'b0;
        tick();
        if (if_hold !== 1'b0 || mop_en !== 1'b0) begin errors++; $display("FAIL async_after got hold=%b en=%b want 0 0", if_hold, mop_en); end
        checks++;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        if_pc = '0; if_insn = '0; if_en = 1'b0;
        test_reset();
        test_pass_through();
        test_ldm_seq();
        test_stm_wrap();
        test_illegal();
        test_stall();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
